mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port SRAM arbiter between the instruction-fetch stage and the MEM stage of the pipeline. It grants one requester at a time, sequences the multi-cycle SRAM read/write strobes, returns read data with a one-cycle acknowledge, and raises `MemConflict` so the fetch stage can stall when the data side holds the memory. Data accesses have fixed priority over fetches.

## Interface
Parameters:
- `ADDR_W`, 16: address width, both requesters and SRAM.
- `DATA_W`, 16: data width.
- `ACCESS_CYCLES`, 2: cycles the SRAM strobes are held per access; legal range 1–15.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address (the PC).
- `if_rdata`  out  DATA_W  fetched instruction; valid while `if_ack` is high, then held.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `mem_req`  in  1  data request; held until `mem_ack`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  ADDR_W  data address.
- `mem_wdata`  in  DATA_W  write data.
- `mem_rdata`  out  DATA_W  load data; valid while `mem_ack` is high, then held.
- `mem_ack`  out  1  one-cycle data completion pulse.
- `MemConflict`  out  1  high while a pending fetch is blocked by the data side.
- `ram_addr`  out  ADDR_W  SRAM address.
- `ram_wdata`  out  DATA_W  SRAM write data.
- `ram_data_oe`  out  1  drive enable for the top-level tristate data bus.
- `ram_rdata`  in  DATA_W  SRAM read data from the bus.
- `ram_en_n`, `ram_oe_n`, `ram_we_n`  out  1 each  active-low SRAM chip enable, output enable, write enable.

## Operation
- States: IDLE, ACCESS, FINISH.
- IDLE: if `mem_req` → grant MEM; else if `if_req` → grant IF; else stay. On grant, latch owner, `we` (0 for IF), address, write data into internal registers; load down-counter with `ACCESS_CYCLES-1`; go to ACCESS.
- ACCESS: `ram_en_n`=0; read: `ram_oe_n`=0; write: `ram_we_n`=0, `ram_data_oe`=1. Counter decrements each cycle; at 0 go to FINISH. On read, `ram_rdata` is captured into the owner's rdata register on the exiting edge.
- FINISH: owner's ack = 1 for exactly this cycle; all strobes deasserted except for a write, where `ram_data_oe` stays 1 and `ram_addr`/`ram_wdata` stay stable (hold time). Always return to IDLE; no rearbitration in FINISH, so a requester still holding req in its ack cycle is never served twice.
- `ram_addr`/`ram_wdata` come from latched registers, so they are stable for the whole transaction regardless of input changes.
- Request dropped mid-transaction: transaction completes, ack still pulses.
- `MemConflict` (combinational) = `if_req` & ((state≠IDLE & owner=MEM) | (state=IDLE & `mem_req`)).
- Starvation: fetch waits indefinitely under continuous `mem_req`; the pipeline guarantees MEM requests are not back-to-back forever.

## Timing
- Reset (async, immediate): state IDLE; `ram_en_n`=`ram_oe_n`=`ram_we_n`=1; `ram_data_oe`=0; `if_ack`=`mem_ack`=0; `MemConflict`=0 unless `mem_req`&`if_req`; `if_rdata`, `mem_rdata`, `ram_addr`, `ram_wdata` = 0. Reset mid-access aborts with strobes released in the same instant; no ack.
- Request sampled at edge E0 in IDLE → strobes active E0..E(N), N=`ACCESS_CYCLES`; ack high E(N)..E(N+1); IDLE again at E(N+1).
- Occupancy N+2 cycles per transaction, including the IDLE cycle; max throughput one access per N+2 cycles.
- Reads and writes have identical latency.
- Simultaneous `if_req` and `mem_req` in IDLE: MEM wins; IF granted at the IDLE following MEM's FINISH if `mem_req` is then low.

## Test plan
- Reset: assert `rst`=0 mid-ACCESS of a write → `ram_we_n`=1, `ram_data_oe`=0, no ack, state IDLE; release → idle outputs as specified.
- Single fetch, N=2: `if_req`=1, `if_addr`=0x0004, `ram_rdata`=0x4815 → `ram_oe_n` low 2 cycles, `if_ack` pulses 3 cycles after sampling, `if_rdata`=0x4815 held afterwards.
- Write: `mem_req`=1, `mem_we`=1, addr 0x0010, data 0xBEEF → `ram_we_n` low 2 cycles, `ram_data_oe` high 3 cycles, `ram_wdata`=0xBEEF stable throughout, `mem_ack` in the last cycle.
- Collision: `if_req`, `mem_req` (read 0x0020 → 0x1234) same cycle → MEM served first, `MemConflict`=1 from that cycle through MEM FINISH, then fetch served; `mem_ack` precedes `if_ack` by 4 cycles.
- Held req in ack cycle: keep `if_req`=1 for one cycle after `if_ack` with the same address → exactly one more fetch, not two extra; changing `if_addr` mid-ACCESS leaves `ram_addr` unchanged.
- Parameter sweep N=1 and N=15 → ack latency N+1 after sampling, counter has no wrap errors.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port SRAM arbiter between fetch and MEM stage.
// Data side wins ties; each access holds the strobes ACCESS_CYCLES.
module mem_arbiter #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 16,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ack,
   output logic              MemConflict,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_data_oe,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              ram_en_n,
   output logic              ram_oe_n,
   output logic              ram_we_n
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      FINISH
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

   state_t     state;
   logic       owner_mem;
   logic       we;
   logic [3:0] cnt;
   logic       grant_we;

   assign grant_we = mem_req & mem_we;

   // Fetch must stall whenever the data side holds or is about to take the SRAM
   assign MemConflict = if_req &
      (((state != IDLE) & owner_mem) |
       ((state == IDLE) & mem_req));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         owner_mem   <= 1'b0;
         we          <= 1'b0;
         cnt         <= '0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         ram_en_n    <= 1'b1;
         ram_oe_n    <= 1'b1;
         ram_we_n    <= 1'b1;
         ram_data_oe <= 1'b0;
         if_ack      <= 1'b0;
         mem_ack     <= 1'b0;
         if_rdata    <= '0;
         mem_rdata   <= '0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (mem_req | if_req) begin
                  owner_mem   <= mem_req;
                  we          <= grant_we;
                  ram_addr    <= mem_req ? mem_addr : if_addr;
                  if (mem_req)
                     ram_wdata <= mem_wdata;
                  cnt         <= CNT_INIT;
                  state       <= ACCESS;
                  ram_en_n    <= 1'b0;
                  ram_oe_n    <= grant_we;
                  ram_we_n    <= ~grant_we;
                  ram_data_oe <= grant_we;
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  state    <= FINISH;
                  ram_en_n <= 1'b1;
                  ram_oe_n <= 1'b1;
                  ram_we_n <= 1'b1;
                  if (owner_mem) begin
                     mem_ack <= 1'b1;
                     if (!we)
                        mem_rdata <= ram_rdata;
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= ram_rdata;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            FINISH: begin
               // Bus drive held one extra cycle for write hold time
               ram_data_oe <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed stimulus on three arbiters
// (N=2, 1, 15) against a transaction-timeline reference model.
module tb_mem_arbiter;

   localparam int NI = 3;

   function automatic int ncyc(input int k);
      return (k == 0) ? 2 : (k == 1) ? 1 : 15;
   endfunction

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        if_req      [NI];
   logic [15:0] if_addr     [NI];
   logic [15:0] if_rdata    [NI];
   logic        if_ack      [NI];
   logic        mem_req     [NI];
   logic        mem_we      [NI];
   logic [15:0] mem_addr    [NI];
   logic [15:0] mem_wdata   [NI];
   logic [15:0] mem_rdata   [NI];
   logic        mem_ack     [NI];
   logic        MemConflict [NI];
   logic [15:0] ram_addr    [NI];
   logic [15:0] ram_wdata   [NI];
   logic        ram_data_oe [NI];
   logic [15:0] ram_rdata   [NI];
   logic        ram_en_n    [NI];
   logic        ram_oe_n    [NI];
   logic        ram_we_n    [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_arbiter #(
         .ADDR_W(16),
         .DATA_W(16),
         .ACCESS_CYCLES(ncyc(g))
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .if_req(if_req[g]),
         .if_addr(if_addr[g]),
         .if_rdata(if_rdata[g]),
         .if_ack(if_ack[g]),
         .mem_req(mem_req[g]),
         .mem_we(mem_we[g]),
         .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]),
         .mem_rdata(mem_rdata[g]),
         .mem_ack(mem_ack[g]),
         .MemConflict(MemConflict[g]),
         .ram_addr(ram_addr[g]),
         .ram_wdata(ram_wdata[g]),
         .ram_data_oe(ram_data_oe[g]),
         .ram_rdata(ram_rdata[g]),
         .ram_en_n(ram_en_n[g]),
         .ram_oe_n(ram_oe_n[g]),
         .ram_we_n(ram_we_n[g])
      );
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got %0h expected %0h",
                  tag, $time, got, exp);
      end
   endtask

   // Reference: each grant at edge st occupies edges st..st+N+1
   int          t;
   int          st  [NI];
   int          fr  [NI];
   bit          mo  [NI];
   bit          mw  [NI];
   logic [15:0] ma  [NI];
   logic [15:0] mwd [NI];
   logic [15:0] mir [NI];
   logic [15:0] mmr [NI];
   int          ihold [NI];
   int          mhold [NI];

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         st[k]  = -1000;
         fr[k]  = 0;
         mo[k]  = 1'b0;
         mw[k]  = 1'b0;
         ma[k]  = '0;
         mwd[k] = '0;
         mir[k] = '0;
         mmr[k] = '0;
      end
   endtask

   task automatic model_edge(input int k);
      int n;
      n = ncyc(k);
      if (t == st[k] + n && !mw[k]) begin
         if (mo[k]) mmr[k] = ram_rdata[k];
         else       mir[k] = ram_rdata[k];
      end
      if (t >= fr[k] && (mem_req[k] || if_req[k])) begin
         st[k] = t;
         fr[k] = t + n + 2;
         mo[k] = mem_req[k];
         mw[k] = mem_req[k] && mem_we[k];
         ma[k] = mem_req[k] ? mem_addr[k] : if_addr[k];
         if (mem_req[k]) mwd[k] = mem_wdata[k];
      end
   endtask

   task automatic check_out(input int k);
      int       d;
      int       n;
      bit       act;
      bit       fin;
      logic [5:0] ev;
      logic [5:0] gv;
      n   = ncyc(k);
      d   = t - st[k];
      act = (d >= 0) && (d < n);
      fin = (d == n);
      ev  = {~act, ~(act & ~mw[k]), ~(act & mw[k]),
             mw[k] & (act | fin), fin & ~mo[k], fin & mo[k]};
      gv  = {ram_en_n[k], ram_oe_n[k], ram_we_n[k],
             ram_data_oe[k], if_ack[k], mem_ack[k]};
      chk($sformatf("strobes%0d", k), 32'(gv), 32'(ev));
      chk($sformatf("ram_addr%0d", k),
          32'(ram_addr[k]), 32'(ma[k]));
      chk($sformatf("if_rdata%0d", k),
          32'(if_rdata[k]), 32'(mir[k]));
      chk($sformatf("mem_rdata%0d", k),
          32'(mem_rdata[k]), 32'(mmr[k]));
      if (mw[k] && (act || fin))
         chk($sformatf("ram_wdata%0d", k),
             32'(ram_wdata[k]), 32'(mwd[k]));
   endtask

   task automatic check_conf(input int k);
      int d;
      bit busy;
      bit ec;
      d    = t - st[k];
      busy = (d >= 0) && (d <= ncyc(k));
      ec   = if_req[k] &
             ((busy & mo[k]) | (~busy & mem_req[k]));
      chk($sformatf("conflict%0d", k),
          32'(MemConflict[k]), 32'(ec));
   endtask

   task automatic step();
      #1;
      for (int k = 0; k < NI; k++) check_conf(k);
      @(posedge clk);
      t++;
      if (rst)
         for (int k = 0; k < NI; k++) model_edge(k);
      #1;
      for (int k = 0; k < NI; k++) check_out(k);
      @(negedge clk);
   endtask

   task automatic xact(input int k, input bit m, input bit w,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] rd, input int hold,
                       input bit chg, output int lat,
                       output int sc, output int dc);
      lat = -1;
      sc  = 0;
      dc  = 0;
      ram_rdata[k] = rd;
      if (m) begin
         mem_req[k]   = 1'b1;
         mem_we[k]    = w;
         mem_addr[k]  = a;
         mem_wdata[k] = wd;
      end else begin
         if_req[k]  = 1'b1;
         if_addr[k] = a;
      end
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         step();
         if (!ram_en_n[k]) sc++;
         if (ram_data_oe[k]) dc++;
         if (m ? mem_ack[k] : if_ack[k]) lat = i;
         if (chg && i == 1 && !m) if_addr[k] = ~a;
      end
      if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
      if (chg) chk("addr_stable", 32'(ram_addr[k]), 32'(a));
      repeat (hold) step();
      if (m) mem_req[k] = 1'b0;
      else   if_req[k]  = 1'b0;
   endtask

   task automatic drive_rand();
      for (int k = 0; k < NI; k++) begin
         ram_rdata[k] = 16'($urandom);
         if (ihold[k] > 0) begin
            ihold[k]--;
            if (ihold[k] == 0) if_req[k] = 1'b0;
         end else if (if_req[k] && if_ack[k]) begin
            ihold[k] = $urandom_range(2);
            if (ihold[k] == 0) if_req[k] = 1'b0;
         end else if (if_req[k]) begin
            if ($urandom_range(39) == 0) if_req[k] = 1'b0;
            else if ($urandom_range(9) == 0)
               if_addr[k] = 16'($urandom);
         end else if ($urandom_range(2) == 0) begin
            if_req[k]  = 1'b1;
            if_addr[k] = 16'($urandom);
         end
         if (mhold[k] > 0) begin
            mhold[k]--;
            if (mhold[k] == 0) mem_req[k] = 1'b0;
         end else if (mem_req[k] && mem_ack[k]) begin
            mhold[k] = $urandom_range(2);
            if (mhold[k] == 0) mem_req[k] = 1'b0;
         end else if (mem_req[k]) begin
            if ($urandom_range(39) == 0) mem_req[k] = 1'b0;
         end else if ($urandom_range(3) == 0) begin
            mem_req[k]   = 1'b1;
            mem_we[k]    = 1'($urandom);
            mem_addr[k]  = 16'($urandom);
            mem_wdata[k] = 16'($urandom);
         end
      end
   endtask

   int lat;
   int sc;
   int dc;
   int ia;
   int mack;
   int cnt;

   initial begin
      rst = 1'b0;
      t   = 0;
      for (int k = 0; k < NI; k++) begin
         if_req[k]    = 1'b0;
         if_addr[k]   = '0;
         mem_req[k]   = 1'b0;
         mem_we[k]    = 1'b0;
         mem_addr[k]  = '0;
         mem_wdata[k] = '0;
         ram_rdata[k] = '0;
         ihold[k]     = 0;
         mhold[k]     = 0;
      end
      model_reset();
      step();
      step();
      chk("rst_wdata", 32'(ram_wdata[0]), 32'h0);
      chk("rst_en_n", 32'(ram_en_n[0]), 32'h1);
      rst = 1'b1;
      step();

      xact(0, 0, 0, 16'h0004, 16'h0, 16'h4815, 0, 1, lat, sc, dc);
      chk("fetch_lat", lat, 3);
      chk("fetch_en_cycles", sc, 2);
      repeat (3) step();
      chk("fetch_hold", 32'(if_rdata[0]), 32'h4815);

      xact(0, 1, 1, 16'h0010, 16'hBEEF, 16'h0, 0, 0, lat, sc, dc);
      chk("wr_lat", lat, 3);
      chk("wr_en_cycles", sc, 2);
      chk("wr_oe_cycles", dc, 3);
      chk("wr_wdata", 32'(ram_wdata[0]), 32'hBEEF);
      step();

      ram_rdata[0] = 16'h1234;
      mem_req[0]   = 1'b1;
      mem_we[0]    = 1'b0;
      mem_addr[0]  = 16'h0020;
      if_req[0]    = 1'b1;
      if_addr[0]   = 16'h0040;
      ia   = -1;
      mack = -1;
      for (int i = 1; i <= 40 && ia < 0; i++) begin
         step();
         if (mem_ack[0]) begin
            mack = i;
            mem_req[0] = 1'b0;
         end
         if (if_ack[0]) begin
            ia = i;
            if_req[0] = 1'b0;
         end
      end
      chk("coll_mem_first", mack, 3);
      chk("coll_gap", ia - mack, 4);
      chk("coll_rdata", 32'(mem_rdata[0]), 32'h1234);
      mem_req[0] = 1'b0;
      if_req[0]  = 1'b0;
      step();

      xact(0, 0, 0, 16'h0100, 16'h0, 16'h5555, 2, 0, lat, sc, dc);
      cnt = 0;
      repeat (10) begin
         step();
         if (if_ack[0]) cnt++;
      end
      chk("held_extra_fetches", cnt, 1);

      mem_req[0]   = 1'b1;
      mem_we[0]    = 1'b1;
      mem_addr[0]  = 16'h0030;
      mem_wdata[0] = 16'hA5A5;
      step();
      step();
      rst = 1'b0;
      model_reset();
      #1;
      chk("rst_mid_we_n", 32'(ram_we_n[0]), 32'h1);
      chk("rst_mid_oe", 32'(ram_data_oe[0]), 32'h0);
      chk("rst_mid_ack", 32'(mem_ack[0]), 32'h0);
      mem_req[0] = 1'b0;
      step();
      rst = 1'b1;
      step();
      step();
      chk("post_rst_addr", 32'(ram_addr[0]), 32'h0);

      xact(1, 0, 0, 16'h0AAA, 16'h0, 16'h1111, 0, 0, lat, sc, dc);
      chk("n1_lat", lat, 2);
      xact(2, 1, 0, 16'h0BBB, 16'h0, 16'h2222, 0, 0, lat, sc, dc);
      chk("n15_lat", lat, 16);
      chk("n15_en_cycles", sc, 15);
      chk("n15_rdata", 32'(mem_rdata[2]), 32'h2222);
      step();
      xact(2, 1, 1, 16'h0CCC, 16'h3333, 16'h0, 0, 0, lat, sc, dc);
      chk("n15_wr_oe", dc, 16);
      step();

      repeat (3000) begin
         drive_rand();
         step();
      end
      for (int k = 0; k < NI; k++) begin
         if_req[k]  = 1'b0;
         mem_req[k] = 1'b0;
      end
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
